axi_rd_burst_mem: RTL and testbench

// - AXI4 read-channel responder (slave) backed by a 64-bit-wide word memory. It is the memory side of the icache/dcache line-fill burst.
// - Accepts one AR request at a time, then returns arlen+1 beats on R with correct rlast/rresp.
// - Honours rready backpressure.
// - Used as the NPC simulation memory and as the fill target in cache unit benches.

---
 rtl/axi_rd_burst_mem_pkg.sv | 17 +
 rtl/axi_burst_addr_gen.sv | 24 ++
 rtl/axi_rd_burst_mem.sv | 151 +++++++++++++++
 tb/tb_axi_rd_burst_mem.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_burst_mem_pkg.sv
// axi_rd_burst_mem_pkg: AXI burst/response encodings, read FSM states and burst error helper
package axi_rd_burst_mem_pkg;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
    localparam logic [1:0] AXI_BURST_RSVD  = 2'b11;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BEAT} rd_state_t;

    // A request is unservable as a whole when the beat exceeds the 64-bit bus,
    // the burst type is reserved, or a WRAP length is not a legal power of two.
    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size, input logic wrap_ok);
        return size > 3'd3 || burst == AXI_BURST_RSVD || (burst == AXI_BURST_WRAP && !wrap_ok);
    endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for FIXED/INCR/WRAP bursts
// Ports: addr (current beat byte address), burst, size (log2 bytes), len (beats-1)
//        -> next_addr (following beat), wrap_ok (len is a legal WRAP length)
module axi_burst_addr_gen
    import axi_rd_burst_mem_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  burst,
    input  logic [2:0]  size,
    input  logic [7:0]  len,
    output logic [31:0] next_addr,
    output logic        wrap_ok
);
    logic [31:0] bytes, incr, cont, wrap_base;
    always_comb begin
        bytes     = 32'd1 << size;
        incr      = (addr & ~(bytes - 32'd1)) + bytes;
        cont      = bytes * ({24'd0, len} + 32'd1);
        wrap_base = addr & ~(cont - 32'd1);
        wrap_ok   = len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
        next_addr = burst == AXI_BURST_FIXED ? addr :
                    burst == AXI_BURST_WRAP  ? (wrap_base | (incr & (cont - 32'd1))) : incr;
    end
endmodule

// File: rtl/axi_rd_burst_mem.sv
// axi_rd_burst_mem: AXI4 read-channel responder backed by a 64-bit word memory
module axi_rd_burst_mem
  import axi_rd_burst_mem_pkg::*;
#(
  parameter int          MEM_WORDS  = 65536,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          RD_LATENCY = 0,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  input  logic [1:0]  arburst,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  output logic        rlast,
  input  logic        rready
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [63:0] mem [MEM_WORDS];
  rd_state_t   state, state_n;
  logic [31:0] addr, addr_n, ld_addr, off, word, g_addr, next_addr;
  logic [1:0]  burst, burst_n, g_burst, rresp_n;
  logic [2:0]  size, size_n, g_size;
  logic [7:0]  len, len_n, g_len, beat_cnt, beat_n, beat_inc, lat_cnt, lat_n;
  logic        err, err_n, ar_err, wrap_ok, ld, ld_err, ld_last, in_rng;
  logic        rvalid_n, rlast_n;
  logic [63:0] rdata_n;

  assign arready  = state == RD_IDLE;
  assign g_addr   = arready ? araddr : addr;
  assign g_burst  = arready ? arburst : (err ? AXI_BURST_INCR : burst);
  assign g_size   = arready ? arsize : size;
  assign g_len    = arready ? arlen : len;
  assign ar_err   = burst_err(arburst, arsize, wrap_ok);
  assign beat_inc = beat_cnt + 8'd1;

  axi_burst_addr_gen u_addr_gen (
    .addr      (g_addr),
    .burst     (g_burst),
    .size      (g_size),
    .len       (g_len),
    .next_addr (next_addr),
    .wrap_ok   (wrap_ok)
  );

  always_comb begin
    state_n  = state;
    addr_n   = addr;
    burst_n  = burst;
    len_n    = len;
    size_n   = size;
    err_n    = err;
    beat_n   = beat_cnt;
    lat_n    = lat_cnt;
    rvalid_n = rvalid;
    rlast_n  = rlast;
    rresp_n  = rresp;
    rdata_n  = rdata;
    ld       = 1'b0;
    ld_addr  = addr;
    ld_err   = err;
    ld_last  = 1'b0;
    case (state)
      RD_IDLE: if (arvalid) begin
        addr_n  = araddr;
        burst_n = arburst;
        len_n   = arlen;
        size_n  = arsize;
        err_n   = ar_err;
        beat_n  = 8'd0;
        if (RD_LATENCY == 0) begin
          state_n = RD_BEAT;
          ld      = 1'b1;
          ld_addr = araddr;
          ld_err  = ar_err;
          ld_last = arlen == 8'd0;
        end else begin
          state_n = RD_WAIT;
          lat_n   = 8'(RD_LATENCY);
        end
      end
      RD_WAIT: begin
        lat_n = lat_cnt - 8'd1;
        if (lat_cnt == 8'd1) begin
          state_n = RD_BEAT;
          ld      = 1'b1;
          ld_last = len == 8'd0;
        end
      end
      RD_BEAT: if (rready) begin
        if (rlast) begin
          state_n  = RD_IDLE;
          rvalid_n = 1'b0;
          rlast_n  = 1'b0;
        end else begin
          beat_n  = beat_inc;
          addr_n  = next_addr;
          ld      = 1'b1;
          ld_addr = next_addr;
          ld_last = beat_inc == len;
        end
      end
      default: state_n = RD_IDLE;
    endcase
    off    = ld_addr - BASE_ADDR;
    word   = off >> 3;
    in_rng = ld_addr >= BASE_ADDR && word < 32'(MEM_WORDS);
    if (ld) begin
      rvalid_n = 1'b1;
      rlast_n  = ld_last;
      rresp_n  = (ld_err || !in_rng) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      rdata_n  = in_rng ? mem[word[AW-1:0]] : 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RD_IDLE;
      addr     <= 32'd0;
      burst    <= 2'd0;
      len      <= 8'd0;
      size     <= 3'd0;
      err      <= 1'b0;
      beat_cnt <= 8'd0;
      lat_cnt  <= 8'd0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rresp    <= AXI_RESP_OKAY;
      rdata    <= 64'd0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      burst    <= burst_n;
      len      <= len_n;
      size     <= size_n;
      err      <= err_n;
      beat_cnt <= beat_n;
      lat_cnt  <= lat_n;
      rvalid   <= rvalid_n;
      rlast    <= rlast_n;
      rresp    <= rresp_n;
      rdata    <= rdata_n;
    end
  end
endmodule

// File: tb/tb_axi_rd_burst_mem.sv
// tb_axi_rd_burst_mem: directed bench for the AXI read burst responder
module tb_axi_rd_burst_mem;
    import axi_rd_burst_mem_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] araddr = 32'd0;
    logic        arvalid = 1'b0, arvalid4 = 1'b0;
    logic [1:0]  arburst = 2'd0;
    logic [7:0]  arlen = 8'd0;
    logic [2:0]  arsize = 3'd0;
    logic        arready, rvalid, rlast, rready = 1'b0;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        arready4, rvalid4, rlast4, rready4 = 1'b0;
    logic [63:0] rdata4;
    logic [1:0]  rresp4;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    axi_rd_burst_mem u0 (
        .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arburst(arburst),
        .arlen(arlen), .arsize(arsize), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rvalid(rvalid), .rlast(rlast), .rready(rready)
    );

    axi_rd_burst_mem #(.RD_LATENCY(4)) u4 (
        .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid4), .arburst(arburst),
        .arlen(arlen), .arsize(arsize), .arready(arready4), .rdata(rdata4), .rresp(rresp4),
        .rvalid(rvalid4), .rlast(rlast4), .rready(rready4)
    );

    function automatic logic [63:0] pat(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'h0F0F_0000 ^ 32'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ar(input logic [31:0] a, input logic [1:0] b, input logic [7:0] l, input logic [2:0] s);
        int w = 0;
        araddr  = a;
        arburst = b;
        arlen   = l;
        arsize  = s;
        arvalid = 1'b1;
        while (!arready && w < 20) begin
            tick();
            w++;
        end
        check("ar_accept", arready, 1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic rbeat(input string tag, input bit chk_d, input logic [63:0] d, input logic [1:0] r, input logic l);
        rready = 1'b1;
        check({tag, "_v"}, rvalid, 1);
        if (chk_d) check({tag, "_d"}, rdata, d);
        check({tag, "_r"}, rresp, r);
        check({tag, "_l"}, rlast, l);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            u0.mem[i] = pat(i);
            u4.mem[i] = pat(i);
        end
        for (int i = 65532; i < 65536; i++) u0.mem[i] = pat(i);
        tick();
        tick();
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_arready", arready, 1);
        rst = 1'b0;
        rready = 1'b1;
        tick();

        ar(32'h8000_0040, AXI_BURST_INCR, 8'd7, 3'd3);
        check("incr_busy", arready, 0);
        for (int k = 0; k < 8; k++) rbeat($sformatf("incr%0d", k), 1, pat(8 + k), AXI_RESP_OKAY, k == 7);
        check("incr_end_v", rvalid, 0);
        check("incr_end_ar", arready, 1);

        ar(32'h8000_0040, AXI_BURST_INCR, 8'd7, 3'd3);
        begin
            int k = 0;
            for (int c = 0; c < 40 && k < 8; c++) begin
                rready = (c % 3 == 0);
                check("bp_v", rvalid, 1);
                check("bp_d", rdata, pat(8 + k));
                check("bp_l", rlast, k == 7);
                if (rready) k++;
                tick();
            end
            check("bp_count", k, 8);
        end
        rready = 1'b1;
        check("bp_end_v", rvalid, 0);

        ar(32'h8000_0010, AXI_BURST_WRAP, 8'd3, 3'd3);
        rbeat("wrap0", 1, pat(2), AXI_RESP_OKAY, 0);
        rbeat("wrap1", 1, pat(3), AXI_RESP_OKAY, 0);
        rbeat("wrap2", 1, pat(0), AXI_RESP_OKAY, 0);
        rbeat("wrap3", 1, pat(1), AXI_RESP_OKAY, 1);
        check("wrap_end_v", rvalid, 0);

        ar(32'h8000_0000, AXI_BURST_WRAP, 8'd2, 3'd3);
        for (int k = 0; k < 3; k++) rbeat($sformatf("wrapbad%0d", k), 0, 64'd0, AXI_RESP_SLVERR, k == 2);
        check("wrapbad_end_v", rvalid, 0);

        ar(32'h8000_0018, AXI_BURST_FIXED, 8'd2, 3'd3);
        for (int k = 0; k < 3; k++) rbeat($sformatf("fixed%0d", k), 1, pat(3), AXI_RESP_OKAY, k == 2);

        ar(32'h8007_FFF8, AXI_BURST_INCR, 8'd3, 3'd3);
        rbeat("edge0", 1, pat(65535), AXI_RESP_OKAY, 0);
        for (int k = 1; k < 4; k++) rbeat($sformatf("edge%0d", k), 1, 64'd0, AXI_RESP_SLVERR, k == 3);
        check("edge_end_v", rvalid, 0);

        ar(32'h8000_0000, AXI_BURST_INCR, 8'd7, 3'd3);
        for (int k = 0; k < 3; k++) rbeat($sformatf("pre_rst%0d", k), 1, pat(k), AXI_RESP_OKAY, 0);
        check("mid_v", rvalid, 1);
        check("mid_d", rdata, pat(3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_v", rvalid, 0);
        check("post_rst_l", rlast, 0);
        check("post_rst_ar", arready, 1);
        ar(32'h8000_0008, AXI_BURST_INCR, 8'd0, 3'd3);
        rbeat("single", 1, pat(1), AXI_RESP_OKAY, 1);
        check("single_end_v", rvalid, 0);

        ar(32'h8000_0000, AXI_BURST_INCR, 8'd255, 3'd3);
        begin
            int n = 0, lastk = -1;
            for (int c = 0; c < 300 && n < 256; c++) begin
                if (rvalid && rlast && lastk < 0) lastk = n;
                if (rvalid) n++;
                tick();
            end
            check("long_count", n, 256);
            check("long_last", lastk, 255);
            check("long_end_v", rvalid, 0);
        end

        araddr   = 32'h8000_0020;
        arburst  = AXI_BURST_INCR;
        arlen    = 8'd1;
        arsize   = 3'd3;
        rready4  = 1'b1;
        arvalid4 = 1'b1;
        check("lat_ar_idle", arready4, 1);
        tick();
        arvalid4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lat_wait_ar%0d", i), arready4, 0);
            check($sformatf("lat_wait_v%0d", i), rvalid4, 0);
            tick();
        end
        check("lat_b0_v", rvalid4, 1);
        check("lat_b0_d", rdata4, pat(4));
        check("lat_b0_l", rlast4, 0);
        tick();
        check("lat_b1_v", rvalid4, 1);
        check("lat_b1_d", rdata4, pat(5));
        check("lat_b1_l", rlast4, 1);
        check("lat_b1_ar", arready4, 0);
        tick();
        check("lat_end_v", rvalid4, 0);
        check("lat_end_ar", arready4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
